// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive-side byte buffer.
//   UART_DATA_W     : width of a received UART byte
//   DEF_DEPTH       : default FIFO depth
//   DEF_ERR_CNT_W   : default framing-error counter width
package uart_rx_fifo_pkg;

    localparam int unsigned UART_DATA_W   = 8;
    localparam int unsigned DEF_DEPTH     = 16;
    localparam int unsigned DEF_ERR_CNT_W = 8;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/sync_byte_fifo.sv
// Synchronous byte FIFO with show-ahead read port.
//   clk, rst     : clock, asynchronous active-high reset
//   i_push, i_din: write request and data (caller guarantees space or a same-cycle pop)
//   i_pop        : read request (ignored while empty)
//   o_dout       : head-of-FIFO byte, combinational from memory
//   o_count      : occupancy 0..DEPTH
//   o_full       : occupancy == DEPTH
//   o_empty      : occupancy == 0
module sync_byte_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter  int unsigned DEPTH  = DEF_DEPTH,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [UART_DATA_W-1:0] i_din,
    input  logic                   i_pop,
    output logic [UART_DATA_W-1:0] o_dout,
    output logic [ADDR_W:0]        o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    uart_byte_t          r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic                w_push;
    logic                w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (ADDR_W+1)'(DEPTH));
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    // A push while full is only legal alongside a pop that frees the slot.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer downstream of the Uart8 receiver.
//   clk, rst          : clock, asynchronous active-high reset
//   rxDone/rxErr/rxOut: receiver done strobe, framing error, received byte
//   rdData/rdValid    : show-ahead head byte and non-empty flag
//   rdReady           : consumer accept (pop when rdValid && rdReady)
//   count/full        : occupancy and full flag
//   overflow          : sticky dropped-byte flag
//   errCount          : saturating framing-error counter
//   clrStatus         : synchronous clear of overflow and errCount
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter  int unsigned DEPTH     = DEF_DEPTH,
    parameter  int unsigned ERR_CNT_W = DEF_ERR_CNT_W,
    localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rxDone,
    input  logic                   rxErr,
    input  logic [UART_DATA_W-1:0] rxOut,
    output logic [UART_DATA_W-1:0] rdData,
    output logic                   rdValid,
    input  logic                   rdReady,
    output logic [ADDR_W:0]        count,
    output logic                   full,
    output logic                   overflow,
    output logic [ERR_CNT_W-1:0]   errCount,
    input  logic                   clrStatus
);

    logic                 r_done_prev;
    logic                 r_overflow;
    logic [ERR_CNT_W-1:0] r_err_count;
    logic                 w_cap;
    logic                 w_good;
    logic                 w_bad;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_empty;
    logic                 w_full;

    // Reset value 1 keeps an rxDone already high at release from capturing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done_prev <= 1'b1;
        end else begin
            r_done_prev <= rxDone;
        end
    end

    assign w_cap  = rxDone & ~r_done_prev;
    assign w_good = w_cap & ~rxErr;
    assign w_bad  = w_cap & rxErr;
    assign w_pop  = ~w_empty & rdReady;
    assign w_push = w_good & (~w_full | w_pop);
    assign w_drop = w_good & w_full & ~w_pop;

    sync_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (rxOut),
        .i_pop   (w_pop),
        .o_dout  (rdData),
        .o_count (count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Status: a same-cycle event takes priority over clrStatus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clrStatus) begin
                r_overflow <= 1'b0;
            end

            if (w_bad) begin
                if (clrStatus) begin
                    r_err_count <= ERR_CNT_W'(1);
                end else if (r_err_count != '1) begin
                    r_err_count <= r_err_count + ERR_CNT_W'(1);
                end
            end else if (clrStatus) begin
                r_err_count <= '0;
            end
        end
    end

    assign rdValid  = ~w_empty;
    assign full     = w_full;
    assign overflow = r_overflow;
    assign errCount = r_err_count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxDone;
    logic       rxErr;
    logic [7:0] rxOut;
    logic [7:0] rdData;
    logic       rdValid;
    logic       rdReady;
    logic [4:0] count;
    logic       full;
    logic       overflow;
    logic [7:0] errCount;
    logic       clrStatus;

    int n_total = 0;
    int n_bad   = 0;

    uart_rx_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .rxDone    (rxDone),
        .rxErr     (rxErr),
        .rxOut     (rxOut),
        .rdData    (rdData),
        .rdValid   (rdValid),
        .rdReady   (rdReady),
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .errCount  (errCount),
        .clrStatus (clrStatus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One receiver frame: rxDone rises for one cycle, then falls.
    task automatic send_byte(input logic [7:0] b, input logic err);
        rxOut  = b;
        rxErr  = err;
        rxDone = 1'b1;
        tick();
        rxDone = 1'b0;
        rxErr  = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        rdReady = 1'b1;
        tick();
        rdReady = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        rxDone    = 1'b0;
        rxErr     = 1'b0;
        rxOut     = 8'h00;
        rdReady   = 1'b0;
        clrStatus = 1'b0;
        tick();
        chk("rst_count",    32'(count),    32'd0);
        chk("rst_valid",    32'(rdValid),  32'd0);
        chk("rst_full",     32'(full),     32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_errcnt",   32'(errCount), 32'd0);
        rst = 1'b0;
        tick();

        // 1: single good byte, then pop
        send_byte(8'b1011_0101, 1'b0);
        chk("t1_count", 32'(count),   32'd1);
        chk("t1_valid", 32'(rdValid), 32'd1);
        chk("t1_data",  32'(rdData),  32'hB5);
        pop_one();
        chk("t1_count_after", 32'(count),   32'd0);
        chk("t1_valid_after", 32'(rdValid), 32'd0);

        // 2: framing error frame, then clear
        send_byte(8'h3C, 1'b1);
        chk("t2_count",  32'(count),    32'd0);
        chk("t2_errcnt", 32'(errCount), 32'd1);
        clrStatus = 1'b1;
        tick();
        clrStatus = 1'b0;
        chk("t2_errcnt_clr", 32'(errCount), 32'd0);

        // 3: fill, overflow with 8'hAA, drain in order
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
        chk("t3_full",      32'(full),     32'd1);
        chk("t3_count",     32'(count),    32'd16);
        chk("t3_overflow0", 32'(overflow), 32'd0);
        send_byte(8'hAA, 1'b0);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_count17",  32'(count),    32'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t3_drain%0d", i), 32'(rdData), 32'(i));
            pop_one();
        end
        chk("t3_empty", 32'(rdValid), 32'd0);
        chk("t3_count_end", 32'(count), 32'd0);
        clrStatus = 1'b1;
        tick();
        clrStatus = 1'b0;
        chk("t3_overflow_clr", 32'(overflow), 32'd0);

        // 4: push 8'h55 on the same cycle as a pop while full
        for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 1'b0);
        chk("t4_full", 32'(full), 32'd1);
        rxOut   = 8'h55;
        rxDone  = 1'b1;
        rdReady = 1'b1;
        tick();
        rxDone  = 1'b0;
        rdReady = 1'b0;
        tick();
        chk("t4_overflow", 32'(overflow), 32'd0);
        chk("t4_count",    32'(count),    32'd16);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("t4_drain%0d", i), 32'(rdData), 32'(8'h10 + i));
            pop_one();
        end
        chk("t4_last", 32'(rdData), 32'h55);
        pop_one();
        chk("t4_empty", 32'(count), 32'd0);

        // 5: rxDone held high across reset release
        rxOut  = 8'h77;
        rxDone = 1'b1;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        repeat (100) tick();
        chk("t5_no_cap", 32'(count), 32'd0);
        rxDone = 1'b0;
        tick();
        rxDone = 1'b1;
        tick();
        chk("t5_one_cap", 32'(count), 32'd1);
        repeat (5) tick();
        chk("t5_level_once", 32'(count), 32'd1);
        chk("t5_data", 32'(rdData), 32'h77);
        rxDone = 1'b0;
        tick();
        pop_one();

        // 6: error counter saturation and clear priority
        do_reset();
        chk("t6_rst_count", 32'(count), 32'd0);
        for (int i = 0; i < 300; i++) send_byte(8'(i), 1'b1);
        chk("t6_sat",   32'(errCount), 32'hFF);
        chk("t6_count", 32'(count),    32'd0);
        rxOut     = 8'h00;
        rxErr     = 1'b1;
        rxDone    = 1'b1;
        clrStatus = 1'b1;
        tick();
        rxDone    = 1'b0;
        rxErr     = 1'b0;
        clrStatus = 1'b0;
        chk("t6_clr_vs_err", 32'(errCount), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
